// File: rtl/sipo_deserializer_if.sv
// Serial receive bus for sipo_deserializer: serial input side, parallel ready/valid
// output side and the sticky overflow flag with its clear.
interface sipo_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  din;
    logic                  din_en;
    logic                  sof;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  overflow;
    logic                  ovf_clr;

    // Driver/consumer side: feeds serial bits, accepts words, clears overflow.
    modport master (
        output din, din_en, sof, dout_ready, ovf_clr,
        input  dout, dout_valid, overflow
    );

    // Deserializer side.
    modport slave (
        input  din, din_en, sof, dout_ready, ovf_clr,
        output dout, dout_valid, overflow
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer, LSB first (first bit received lands in dout[0]).
// Frames are realigned by sof, completed words are offered on a registered ready/valid
// output, and a word that completes while the previous one is still unconsumed is
// dropped and flagged on the sticky overflow output.
module sipo_deserializer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    sipo_deserializer_if.slave  bus
);
    localparam int unsigned CntW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] word;
    logic                  xfer;
    logic                  complete;

    // Next-state: shifting, bit counting/framing, output handshake and overflow.
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;

        word     = {bus.din, shift_q[DATA_WIDTH-1:1]};
        xfer     = dout_valid_q & bus.dout_ready;
        // sof starts a fresh frame, so it can never finish the pending one.
        complete = bus.din_en & ~bus.sof & (bit_cnt_q == LastCnt);

        if (bus.din_en) begin
            shift_d = word;
        end

        // Stale shift bits need no clearing on sof: a full frame overwrites all of them.
        if (bus.sof) begin
            bit_cnt_d = bus.din_en ? CntW'(1) : '0;
        end else if (bus.din_en) begin
            bit_cnt_d = complete ? '0 : bit_cnt_q + CntW'(1);
        end

        if (xfer) begin
            dout_valid_d = 1'b0;
        end

        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end

        if (complete) begin
            if (!dout_valid_q || bus.dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                // Old word is still unconsumed: keep it, drop the new one. Set beats clear.
                overflow_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.overflow   = overflow_q;
endmodule
